// File: rtl/flp_pkg.sv
// Shared definitions for the power-of-two floating-point summation blocks:
// default field widths and the stream FSM state encoding.
package flp_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } flp_state_e;

endpackage

// File: rtl/flp_add_pow2.sv
// Combinational step: accumulator (E, 1.M) plus 2^x, with truncating
// alignment, single-bit normalisation and exponent saturation.
module flp_add_pow2 #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 8
) (
  input  logic [EXP_W:0]    acc_exp,
  input  logic [MANT_W-1:0] acc_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic [EXP_W:0]    sum_exp,
  output logic [MANT_W-1:0] sum_mant,
  output logic              ovf
);

  localparam int SW = MANT_W + 2;

  logic [EXP_W:0]   x_ext_s;
  logic [EXP_W:0]   big_exp_s;
  logic [EXP_W:0]   diff_s;
  logic [SW-1:0]    big_sig_s;
  logic [SW-1:0]    small_sig_s;
  logic [SW-1:0]    small_al_s;
  logic [SW-1:0]    sig_sum_s;
  logic [EXP_W+1:0] exp_inc_s;

  assign x_ext_s = {1'b0, in_exp};

  // Align the smaller operand, add, normalise and saturate.
  always_comb begin
    if (acc_exp >= x_ext_s) begin
      big_exp_s   = acc_exp;
      diff_s      = acc_exp - x_ext_s;
      big_sig_s   = {1'b0, 1'b1, acc_mant};
      small_sig_s = {1'b0, 1'b1, {MANT_W{1'b0}}};
    end else begin
      big_exp_s   = x_ext_s;
      diff_s      = x_ext_s - acc_exp;
      big_sig_s   = {1'b0, 1'b1, {MANT_W{1'b0}}};
      small_sig_s = {1'b0, 1'b1, acc_mant};
    end

    if (32'(diff_s) > MANT_W) begin
      small_al_s = {SW{1'b0}};
    end else begin
      small_al_s = small_sig_s >> diff_s;
    end

    sig_sum_s = big_sig_s + small_al_s;

    if (sig_sum_s[SW-1]) begin
      exp_inc_s = {1'b0, big_exp_s} + {{(EXP_W+1){1'b0}}, 1'b1};
      sum_mant  = sig_sum_s[MANT_W:1];
    end else begin
      exp_inc_s = {1'b0, big_exp_s};
      sum_mant  = sig_sum_s[MANT_W-1:0];
    end

    // Carry out of the widened exponent means the result is unrepresentable.
    if (exp_inc_s[EXP_W+1]) begin
      sum_exp  = {(EXP_W+1){1'b1}};
      sum_mant = {MANT_W{1'b1}};
      ovf      = 1'b1;
    end else begin
      sum_exp  = exp_inc_s[EXP_W:0];
      ovf      = 1'b0;
    end
  end

endmodule

// File: rtl/flp_sum_stream.sv
// Streams vectors of 2^x elements and emits their truncated floating-point
// sum, one result per vector, with length-cap and overflow flags.
module flp_sum_stream
  import flp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int N_MAX  = 16,
  localparam int CNT_W = $clog2(N_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W:0]    out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_len_err,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_MAX);

  flp_state_e        state_r, state_s;
  logic [EXP_W:0]    acc_exp_r, acc_exp_s;
  logic [MANT_W-1:0] acc_mant_r, acc_mant_s;
  logic [CNT_W-1:0]  count_r, count_s, count_inc_s;
  logic              len_err_r, len_err_s;
  logic              ovf_r, ovf_s;
  logic              in_ready_r, out_valid_r;
  logic              beat_s, cap_s, term_s;
  logic [EXP_W:0]    add_exp_s;
  logic [MANT_W-1:0] add_mant_s;
  logic              add_ovf_s;

  flp_add_pow2 #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W)
  ) u_add (
    .acc_exp  (acc_exp_r),
    .acc_mant (acc_mant_r),
    .in_exp   (in_exp),
    .sum_exp  (add_exp_s),
    .sum_mant (add_mant_s),
    .ovf      (add_ovf_s)
  );

  // Next-state and accumulator update for one accepted element or result.
  always_comb begin
    state_s    = state_r;
    acc_exp_s  = acc_exp_r;
    acc_mant_s = acc_mant_r;
    count_s    = count_r;
    len_err_s  = len_err_r;
    ovf_s      = ovf_r;

    beat_s      = in_valid && in_ready_r;
    count_inc_s = (state_r == IDLE) ? ONE_CNT : (count_r + ONE_CNT);
    cap_s       = (count_inc_s == MAX_CNT);
    term_s      = in_last || cap_s;

    case (state_r)
      IDLE: begin
        if (beat_s) begin
          acc_exp_s  = {1'b0, in_exp};
          acc_mant_s = {MANT_W{1'b0}};
          count_s    = count_inc_s;
          len_err_s  = cap_s && !in_last;
          ovf_s      = 1'b0;
          state_s    = term_s ? DONE : ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s) begin
          acc_exp_s  = add_exp_s;
          acc_mant_s = add_mant_s;
          count_s    = count_inc_s;
          len_err_s  = cap_s && !in_last;
          ovf_s      = ovf_r || add_ovf_s;
          state_s    = term_s ? DONE : ACCUM;
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, accumulator and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_exp_r   <= {(EXP_W+1){1'b0}};
      acc_mant_r  <= {MANT_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      len_err_r   <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_exp_r   <= acc_exp_s;
      acc_mant_r  <= acc_mant_s;
      count_r     <= count_s;
      len_err_r   <= len_err_s;
      ovf_r       <= ovf_s;
      in_ready_r  <= (state_s != DONE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_exp     = acc_exp_r;
  assign out_mant    = acc_mant_r;
  assign out_count   = count_r;
  assign out_len_err = len_err_r;
  assign out_ovf     = ovf_r;

endmodule

// File: tb/tb_flp_sum_stream.sv
// Self-checking bench: directed vectors, a saturating narrow instance and
// randomized vectors scored against an arithmetic reference model.
module tb_flp_sum_stream;

  localparam int EW  = 8;
  localparam int MW  = 8;
  localparam int NM  = 4;
  localparam int CW  = $clog2(NM + 1);
  localparam int SEW = 1;
  localparam int SMW = 4;
  localparam int SNM = 16;
  localparam int SCW = $clog2(SNM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [EW-1:0] in_exp = '0;
  logic          in_ready, out_valid, out_len_err, out_ovf;
  logic [EW:0]   out_exp;
  logic [MW-1:0] out_mant;
  logic [CW-1:0] out_count;

  logic           s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
  logic [SEW-1:0] s_in_exp = '0;
  logic           s_in_ready, s_out_valid, s_out_len_err, s_out_ovf;
  logic [SEW:0]   s_out_exp;
  logic [SMW-1:0] s_out_mant;
  logic [SCW-1:0] s_out_count;

  int n_checks = 0;
  int n_fail   = 0;

  flp_sum_stream #(.EXP_W(EW), .MANT_W(MW), .N_MAX(NM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_mant(out_mant),
    .out_count(out_count), .out_len_err(out_len_err), .out_ovf(out_ovf)
  );

  flp_sum_stream #(.EXP_W(SEW), .MANT_W(SMW), .N_MAX(SNM)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_exp(s_in_exp), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_exp(s_out_exp), .out_mant(s_out_mant),
    .out_count(s_out_count), .out_len_err(s_out_len_err), .out_ovf(s_out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value 2^e * (1 + m/2^mw) plus 2^x, smaller operand truncated to mw bits.
  function automatic void ref_add(input int ew, input int mw, input longint x,
                                  inout longint e, inout longint m, inout bit ovf);
    longint one, hi_e, d, s, lo;
    one = longint'(1) << mw;
    if (e >= x) begin hi_e = e; d = e - x; s = one + m; lo = one; end
    else        begin hi_e = x; d = x - e; s = one;     lo = one + m; end
    if (d <= mw) s = s + (lo >> d);
    if (s >= 2 * one) begin s = s >> 1; hi_e = hi_e + 1; end
    if (hi_e > (longint'(1) << (ew + 1)) - 1) begin
      e = (longint'(1) << (ew + 1)) - 1; m = one - 1; ovf = 1'b1;
    end else begin
      e = hi_e; m = s - one;
    end
  endfunction

  task automatic send(input int x, input bit last);
    int guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_exp = EW'(x); in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_exp = EW'($urandom); in_last = 1'($urandom);
  endtask

  // Called right after the terminating beat: checks latency, values, stall, drain.
  task automatic expect_result(input string tag, input longint e, input longint m,
                               input int cnt, input bit lerr, input bit ovf, input int hold);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_exp"}, out_exp, e);
    check({tag, "_mant"}, out_mant, m);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_len_err"}, out_len_err, lerr);
    check({tag, "_ovf"}, out_ovf, ovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_exp"}, out_exp, e);
      check({tag, "_hold_mant"}, out_mant, m);
      check({tag, "_hold_count"}, out_count, cnt);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, out_valid, 0);
    check({tag, "_ready_again"}, in_ready, 1);
  endtask

  task automatic run_directed(input string tag, input int xs[$], input bit use_last,
                              input int hold, input longint e, input longint m);
    for (int i = 0; i < xs.size(); i++) send(xs[i], use_last && (i == xs.size() - 1));
    expect_result(tag, e, m, xs.size(), !use_last, 1'b0, hold);
  endtask

  initial begin
    int     xs[$];
    longint re, rm;
    bit     rovf, use_last;
    int     len, base;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_exp", out_exp, 0);
    check("rst_out_mant", out_mant, 0);
    check("rst_out_count", out_count, 0);
    check("rst_len_err", out_len_err, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_directed("v33",   '{3, 3},        1'b1, 0, 4,  8'h00);
    run_directed("v54",   '{5, 4},        1'b1, 0, 5,  8'h80);
    run_directed("v10_0", '{10, 0},       1'b1, 0, 10, 8'h00);
    run_directed("v2222", '{2, 2, 2, 2},  1'b1, 0, 4,  8'h00);
    run_directed("v7",    '{7},           1'b1, 5, 7,  8'h00);
    run_directed("cap",   '{1, 1, 1, 1},  1'b0, 1, 3,  8'h00);
    run_directed("after_cap", '{1, 1},    1'b1, 0, 2,  8'h00);

    // Partial vector abandoned by reset.
    send(9, 1'b0);
    send(9, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_exp", out_exp, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    run_directed("v66", '{6, 6}, 1'b1, 0, 7, 8'h00);

    // Eight elements of 2^1 overflow a 2-bit result exponent.
    s_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_in_exp = 1'b1; s_in_last = (i == 7);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    check("sat_valid", s_out_valid, 1);
    check("sat_exp", s_out_exp, 3);
    check("sat_mant", s_out_mant, 4'hF);
    check("sat_count", s_out_count, 8);
    check("sat_ovf", s_out_ovf, 1);
    check("sat_len_err", s_out_len_err, 0);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("sat_drained", s_out_valid, 0);

    for (int v = 0; v < 25; v++) begin
      xs.delete();
      len = $urandom_range(1, NM);
      use_last = (len < NM) ? 1'b1 : 1'($urandom);
      base = $urandom_range(0, 245);
      for (int i = 0; i < len; i++)
        xs.push_back(($urandom % 2) ? base + $urandom_range(0, 10) : $urandom_range(0, 255));
      re = xs[0]; rm = 0; rovf = 1'b0;
      for (int i = 1; i < len; i++) ref_add(EW, MW, xs[i], re, rm, rovf);
      for (int i = 0; i < len; i++) send(xs[i], use_last && (i == len - 1));
      expect_result("rand", re, rm, len, !use_last, rovf, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flp_sum_stream.md
FLP_SUM_STREAM -- requirements
Module: flp_sum_stream

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning the input exponent width.
REQ-002 SHALL have parameter MANT_W, default 8, meaning the result mantissa fraction width.
REQ-003 SHALL have parameter N_MAX, default 16, meaning the maximum number of elements per vector (N_MAX >= 1).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  input element valid.
REQ-008 in_ready  out  1  block can accept an element.
REQ-009 in_exp  in  EXP_W  unsigned exponent x; the element value is 2^x.
REQ-010 in_last  in  1  marks the final element of the vector.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_exp  out  EXP_W+1  result exponent E.
REQ-014 out_mant  out  MANT_W  result fraction M; the sum is 2^E * (1 + M/2^MANT_W).
REQ-015 out_count  out  clog2(N_MAX+1)  number of elements summed.
REQ-016 out_len_err  out  1  vector was cut at N_MAX without in_last.
REQ-017 out_ovf  out  1  exponent saturated.

Function
REQ-018 SHALL transfer an input beat when in_valid && in_ready, and a result beat when out_valid && out_ready.
REQ-019 SHALL implement FSM states IDLE, ACCUM, DONE: IDLE->ACCUM on the first beat without last; IDLE->DONE on the first beat with last; ACCUM->DONE on the last beat or on beat number N_MAX; DONE->IDLE on a result transfer.
REQ-020 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DONE; out_valid=1 only in DONE.
REQ-021 SHALL load the accumulator to (E=x, M=0) on the first beat, with count=1.
REQ-022 SHALL, on each later beat, add 2^x: L=max(E,x), d=|E-x|, then form significand sum = larger + (smaller >> d) in MANT_W+2 bits, with the input significand equal to 1.0.
REQ-023 SHALL truncate shifted-out bits (round toward zero); for d > MANT_W the smaller operand SHALL contribute 0.
REQ-024 SHALL normalise a sum >= 2.0 by shifting right 1 (truncate) and setting E=L+1; otherwise E=L.
REQ-025 SHALL saturate when E would exceed 2^(EXP_W+1)-1: E=all ones, M=all ones, sticky out_ovf=1 for that vector.
REQ-026 SHALL assert out_valid on the cycle after the terminating beat is accepted (latency 1, throughput 1 element/cycle).
REQ-027 SHALL, when beat N_MAX is accepted with in_last=0, terminate the vector with out_len_err=1; the next input beat starts a new vector.
REQ-028 SHALL hold out_exp, out_mant, out_count and the flags stable while out_valid && !out_ready.
REQ-029 SHALL ignore in_last and in_exp when in_valid=0.

Reset
REQ-030 SHALL, on rst, enter IDLE and clear the accumulator, count and flags; out_valid=0, out_exp=0, out_mant=0, out_count=0, out_len_err=0, out_ovf=0.
REQ-031 SHALL take rst with priority over any simultaneous beat; a partial vector is discarded.

Structure
REQ-032 SHALL place EXP_W/MANT_W defaults and the state enumeration in shared package flp_pkg.
REQ-033 SHALL implement align/add/normalise/saturate as combinational sub-module flp_add_pow2, reusable by future trees.

Verification
REQ-034 Inputs 3, 3(last) -> E=4, M=0x00, count=2.
REQ-035 Inputs 5, 4(last) -> E=5, M=0x80; inputs 10, 0(last) -> E=10, M=0x00 (d>MANT_W).
REQ-036 Inputs 2, 2, 2, 2(last) -> intermediate results (3,0x00), (3,0x80), final E=4, M=0x00, count=4.
REQ-037 Single input 7(last) -> E=7, M=0; with out_ready held low for 5 cycles, the result stays stable and in_ready=0 throughout.
REQ-038 N_MAX=4, five beats of 1 with no last -> first result E=3, M=0, count=4, len_err=1; the fifth beat starts a new vector.
REQ-039 rst asserted after 2 of 3 beats, then vector 6, 6(last) -> E=7, M=0, with no residue from the discarded vector.
